fetch_instruction_queue: RTL
============================

Name: fetch_instruction_queue

Overview:
- Decoupling queue between the fetch stage and decode.
- Captures each completed fetch: instruction word, ID, ok flag and error code. Adds registered pre-decode flags and presents entries to decode in order through a valid/ready handshake.
- Generates a hold request back to fetch so the fetch stage's inflight requests can always land without overflow.
- Flushed by the global fetch flush and by early branch flushes.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- MAX_INFLIGHT, 2, maximum fetch requests outstanding upstream; must be less than DEPTH.
- ID_W, 3, width of the instruction ID field.
- ERR_W, 5, width of the fetch error code.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous queue clear (fetch flush OR early branch flush)
- push_valid  in  1  fetch complete
- push_instruction  in  32  fetched word
- push_id  in  ID_W  ID of fetched instruction
- push_ok  in  1  fetch had no fault
- push_error_code  in  ERR_W  fault cause, meaningful when push_ok=0
- dec_valid  out  1  head entry valid
- dec_ready  in  1  decode accepts head
- dec_instruction  out  32  head word
- dec_id  out  ID_W  head ID
- dec_ok  out  1  head ok flag
- dec_error_code  out  ERR_W  head error code
- dec_is_branch_or_jump  out  1  pre-decode flag: opcode JAL, JALR or BRANCH
- dec_is_mem  out  1  pre-decode flag: opcode LOAD or STORE
- dec_is_system  out  1  pre-decode flag: opcode SYSTEM
- fetch_hold  out  1  request to stop issuing new fetches
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow_err  out  1  sticky: push attempted while full with no pop

Behaviour:
- Storage is a circular buffer with read and write pointers of $clog2(DEPTH) bits each.
  - Pointers wrap naturally from DEPTH-1 to 0.
  - count is a separate register, 0..DEPTH.
- Reset (rst=0, asynchronous): pointers=0, count=0, overflow_err=0.
  - Consequently dec_valid=0 and fetch_hold=0.
  - Data RAM contents are not reset. Data outputs are don't-care while dec_valid=0.
- Definitions: pop = dec_valid & dec_ready; push_eff = push_valid & ~flush & (~full | pop); full = (count==DEPTH).
- Push: on push_eff, the entry at the write pointer is written with all input fields plus pre-decode flags, and the write pointer increments.
  - Pre-decode uses push_instruction[6:2]:
    - JAL=11011, JALR=11001, BRANCH=11000 set dec_is_branch_or_jump.
    - LOAD=00000, STORE=01000 set dec_is_mem.
    - SYSTEM=11100 sets dec_is_system.
  - All flags are forced to 0 when push_ok=0.
- Latency: a pushed entry is visible on dec_* the next cycle. There is no same-cycle bypass.
- Pop: the read pointer increments and the next entry appears the following cycle.
  - dec_* outputs are driven from the entry at the read pointer.
  - dec_valid = (count != 0).
  - dec_* must remain stable while dec_valid & ~dec_ready.
- count_next = count + push_eff - pop.
  - Simultaneous push and pop leaves count unchanged, including when full and when count=1.
- Full with push_valid and no pop: the push is dropped, state is unchanged, and overflow_err sets. It clears only on reset.
- Empty: dec_ready is ignored and no pop occurs.
- Flush (synchronous): next cycle pointers=0, count=0, dec_valid=0.
  - A push or pop in the flush cycle is discarded.
  - overflow_err is unaffected.
- fetch_hold = ((DEPTH - count) <= MAX_INFLIGHT), combinational from the count register only.
  - Fetch may still complete requests already in flight after fetch_hold asserts.
- Reset asserted mid-operation returns all state to reset values immediately, independent of clk.

Test Plan:
- Reset, then single push of 0x00C58063 (BRANCH), push_id=5, push_ok=1 -> next cycle dec_valid=1, dec_instruction=0x00C58063, dec_id=5, dec_is_branch_or_jump=1, count=1; pop with dec_ready=1 -> count=0, dec_valid=0.
- Four back-to-back pushes, IDs 0..3, dec_ready=0 (DEPTH=4) ->
  - count 1,2,3,4.
  - fetch_hold asserts once count=2.
  - Fifth push drops and overflow_err=1.
  - Draining returns IDs 0,1,2,3 in order.
- Full queue with push and pop in the same cycle -> count stays 4, no overflow; six pushes during continuous pops return every ID in order across pointer wrap.
- Push of LOAD 0x0002A303 with push_ok=0, push_error_code=12 -> dec_ok=0, dec_error_code=12, all pre-decode flags 0.
- count=3, flush asserted together with push_valid and dec_ready -> next cycle count=0, dec_valid=0, fetch_hold=0; the following push produces an entry one cycle later.
- Assert rst low asynchronously between clock edges with count=2 -> dec_valid and count drop to 0 before the next edge; overflow_err cleared.

Source files
------------

// File: rtl/fetch_instruction_queue.sv
//------------------------------------------------------------------------------
// Module  : fetch_instruction_queue
// Brief   : In-order fetch-to-decode queue with pre-decode flags and fetch hold.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_instruction_queue #(
  parameter int DEPTH        = 4,
  parameter int MAX_INFLIGHT = 2,
  parameter int ID_W         = 3,
  parameter int ERR_W        = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push_valid,
  input  logic [31:0]                push_instruction,
  input  logic [ID_W-1:0]            push_id,
  input  logic                       push_ok,
  input  logic [ERR_W-1:0]           push_error_code,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [31:0]                dec_instruction,
  output logic [ID_W-1:0]            dec_id,
  output logic                       dec_ok,
  output logic [ERR_W-1:0]           dec_error_code,
  output logic                       dec_is_branch_or_jump,
  output logic                       dec_is_mem,
  output logic                       dec_is_system,
  output logic                       fetch_hold,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] c_depth        = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_max_inflight = CNT_W'(MAX_INFLIGHT);

  localparam logic [4:0] c_op_jal    = 5'b11011;
  localparam logic [4:0] c_op_jalr   = 5'b11001;
  localparam logic [4:0] c_op_branch = 5'b11000;
  localparam logic [4:0] c_op_load   = 5'b00000;
  localparam logic [4:0] c_op_store  = 5'b01000;
  localparam logic [4:0] c_op_system = 5'b11100;

  logic [31:0]      r_instr_mem [DEPTH];
  logic [ID_W-1:0]  r_id_mem    [DEPTH];
  logic             r_ok_mem    [DEPTH];
  logic [ERR_W-1:0] r_err_mem   [DEPTH];
  logic [2:0]       r_flags_mem [DEPTH];

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_overflow;
  logic [CNT_W-1:0] w_count_next;
  logic [CNT_W-1:0] w_free;
  logic [4:0]       w_opcode;
  logic [2:0]       w_flags;

  assign w_full     = (r_count == c_depth);
  assign w_pop      = dec_valid & dec_ready;
  assign w_push     = push_valid & ~flush & (~w_full | w_pop);
  assign w_overflow = push_valid & ~flush & w_full & ~w_pop;

  // Flags are {branch_or_jump, mem, system}; a faulted fetch carries no decode hints.
  assign w_opcode = push_instruction[6:2];
  always_comb begin
    w_flags = 3'b000;
    if (push_ok) begin
      w_flags[2] = (w_opcode == c_op_jal) | (w_opcode == c_op_jalr) | (w_opcode == c_op_branch);
      w_flags[1] = (w_opcode == c_op_load) | (w_opcode == c_op_store);
      w_flags[0] = (w_opcode == c_op_system);
    end
  end

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_instr_mem[r_wr_ptr] <= push_instruction;
      r_id_mem[r_wr_ptr]    <= push_id;
      r_ok_mem[r_wr_ptr]    <= push_ok;
      r_err_mem[r_wr_ptr]   <= push_error_code;
      r_flags_mem[r_wr_ptr] <= w_flags;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_overflow) begin
        r_overflow <= 1'b1;
      end
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        r_count <= w_count_next;
      end
    end
  end

  // Free slots never underflow since count is bounded by DEPTH.
  assign w_free     = c_depth - r_count;
  assign fetch_hold = (w_free <= c_max_inflight);

  assign dec_valid             = (r_count != '0);
  assign dec_instruction       = r_instr_mem[r_rd_ptr];
  assign dec_id                = r_id_mem[r_rd_ptr];
  assign dec_ok                = r_ok_mem[r_rd_ptr];
  assign dec_error_code        = r_err_mem[r_rd_ptr];
  assign dec_is_branch_or_jump = r_flags_mem[r_rd_ptr][2];
  assign dec_is_mem            = r_flags_mem[r_rd_ptr][1];
  assign dec_is_system         = r_flags_mem[r_rd_ptr][0];
  assign count                 = r_count;
  assign overflow_err          = r_overflow;

endmodule

`default_nettype wire
